ui_menu_controller: RTL and testbench



---
 rtl/ui_pkg.sv | 33 +++
 rtl/key_edge.sv | 24 ++
 rtl/ui_menu_controller.sv | 216 +++++++++++++++++++++
 tb/tb_ui_menu_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared types and constants for the front-panel UI controller.
package ui_pkg;

  localparam int GAIN_W         = 5;
  localparam int DEF_NUM_BANDS  = 6;
  localparam int DEF_GAIN_MAX   = 12;
  localparam int DEF_OFFSET_MAX = 4;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_MENU   = 3'd2,
    ST_BAND   = 3'd3,
    ST_GAIN   = 3'd4,
    ST_OFFSET = 3'd5
  } ui_state_e;

  typedef enum logic [1:0] {
    MENU_EQ     = 2'd0,
    MENU_OFFSET = 2'd1,
    MENU_RESET  = 2'd2
  } menu_e;

  // Bands are numbered from 1; band k sits at bit GAIN_W*(k-1) of the table.
  function automatic int band_lsb(input logic [2:0] band);
    return GAIN_W * int'(band - 3'd1);
  endfunction

  function automatic logic [31:0] sext_gain(input logic [GAIN_W-1:0] g);
    return {{(32-GAIN_W){g[GAIN_W-1]}}, g};
  endfunction

endpackage

// File: rtl/key_edge.sv
// Registered previous-level stage turning debounced key levels into press pulses.
module key_edge #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_keys,
  output logic [W-1:0] o_press
);

  logic [W-1:0] prev_r;

  // Previous levels reset high so a key held through reset never fires.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_r <= {W{1'b1}};
    end else begin
      prev_r <= i_keys;
    end
  end

  assign o_press = i_keys & ~prev_r;

endmodule

// File: rtl/ui_menu_controller.sv
// Top-level UI state machine: navigation, per-band gain table, offset and play flag.
module ui_menu_controller
  import ui_pkg::*;
#(
  parameter int NUM_BANDS  = DEF_NUM_BANDS,
  parameter int GAIN_MAX   = DEF_GAIN_MAX,
  parameter int OFFSET_MAX = DEF_OFFSET_MAX
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_init_done,
  input  logic                          i_key_up,
  input  logic                          i_key_down,
  input  logic                          i_key_enter,
  input  logic                          i_key_back,
  output logic [2:0]                    o_state,
  output logic [2:0]                    o_menu_state,
  output logic [2:0]                    o_band,
  output logic [31:0]                   o_gain,
  output logic [GAIN_W*NUM_BANDS-1:0]   o_gain_table,
  output logic [2:0]                    o_offset,
  output logic                          o_play_enable,
  output logic                          o_cfg_update
);

  localparam int TBL_W = GAIN_W * NUM_BANDS;
  localparam logic signed [GAIN_W-1:0] GAIN_HI = GAIN_W'(GAIN_MAX);
  localparam logic signed [GAIN_W-1:0] GAIN_LO = -GAIN_HI;
  localparam logic [2:0] BAND_MAX = 3'(NUM_BANDS);
  localparam logic [2:0] OFS_MAX  = 3'(OFFSET_MAX);

  logic [3:0] press_s;
  logic       back_s, enter_s, up_s, down_s;

  ui_state_e         state_r, state_s;
  menu_e             menu_r, menu_s;
  logic [2:0]        band_r, band_s;
  logic [TBL_W-1:0]  table_r, table_s;
  logic [2:0]        offset_r, offset_s;
  logic              play_r, play_s;
  logic              cfg_r, cfg_s;
  logic [31:0]       gain_r;
  logic signed [GAIN_W-1:0] cur_gain_s, next_gain_s;

  key_edge #(.W(4)) u_key_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_keys  ({i_key_back, i_key_enter, i_key_up, i_key_down}),
    .o_press (press_s)
  );

  // Only the highest-priority press of a cycle acts; the rest are dropped.
  assign back_s  = press_s[3];
  assign enter_s = press_s[2] & ~press_s[3];
  assign up_s    = press_s[1] & ~(|press_s[3:2]);
  assign down_s  = press_s[0] & ~(|press_s[3:1]);

  // Next-state and next-value logic for every UI register.
  always_comb begin
    state_s    = state_r;
    menu_s     = menu_r;
    band_s     = band_r;
    table_s    = table_r;
    offset_s   = offset_r;
    play_s     = play_r;
    cfg_s      = 1'b0;
    cur_gain_s = table_r[band_lsb(band_r) +: GAIN_W];

    case (state_r)
      ST_INIT: begin
        if (i_init_done) state_s = ST_PLAY;
        else             state_s = ST_INIT;
      end
      ST_PLAY: begin
        if (back_s) begin
          state_s = ST_PLAY;
        end else if (enter_s) begin
          state_s = ST_MENU;
          menu_s  = MENU_EQ;
        end else if (up_s || down_s) begin
          play_s = ~play_r;
        end else begin
          play_s = play_r;
        end
      end
      ST_MENU: begin
        if (back_s) begin
          state_s = ST_PLAY;
        end else if (enter_s) begin
          case (menu_r)
            MENU_EQ: begin
              state_s = ST_BAND;
              band_s  = 3'd1;
            end
            MENU_OFFSET: state_s = ST_OFFSET;
            MENU_RESET: begin
              table_s  = {TBL_W{1'b0}};
              offset_s = 3'd0;
              cfg_s    = 1'b1;
              state_s  = ST_PLAY;
            end
            default: menu_s = MENU_EQ;
          endcase
        end else if (up_s) begin
          case (menu_r)
            MENU_EQ:     menu_s = MENU_OFFSET;
            MENU_OFFSET: menu_s = MENU_RESET;
            default:     menu_s = MENU_EQ;
          endcase
        end else if (down_s) begin
          case (menu_r)
            MENU_EQ:     menu_s = MENU_RESET;
            MENU_RESET:  menu_s = MENU_OFFSET;
            default:     menu_s = MENU_EQ;
          endcase
        end else begin
          menu_s = menu_r;
        end
      end
      ST_BAND: begin
        if (back_s) begin
          state_s = ST_MENU;
        end else if (enter_s) begin
          state_s = ST_GAIN;
        end else if (up_s) begin
          if (band_r >= BAND_MAX) band_s = 3'd1;
          else                    band_s = band_r + 3'd1;
        end else if (down_s) begin
          if (band_r <= 3'd1) band_s = BAND_MAX;
          else                band_s = band_r - 3'd1;
        end else begin
          band_s = band_r;
        end
      end
      ST_GAIN: begin
        // Saturation is tested on the current value so the 5-bit store never wraps.
        if (back_s || enter_s) begin
          state_s = ST_BAND;
        end else if (up_s) begin
          if (cur_gain_s < GAIN_HI) begin
            table_s[band_lsb(band_r) +: GAIN_W] = cur_gain_s + 5'sd1;
            cfg_s = 1'b1;
          end else begin
            cfg_s = 1'b0;
          end
        end else if (down_s) begin
          if (cur_gain_s > GAIN_LO) begin
            table_s[band_lsb(band_r) +: GAIN_W] = cur_gain_s - 5'sd1;
            cfg_s = 1'b1;
          end else begin
            cfg_s = 1'b0;
          end
        end else begin
          cfg_s = 1'b0;
        end
      end
      ST_OFFSET: begin
        if (back_s || enter_s) begin
          state_s = ST_MENU;
        end else if (up_s) begin
          if (offset_r < OFS_MAX) begin
            offset_s = offset_r + 3'd1;
            cfg_s    = 1'b1;
          end else begin
            cfg_s = 1'b0;
          end
        end else if (down_s) begin
          if (offset_r > 3'd0) begin
            offset_s = offset_r - 3'd1;
            cfg_s    = 1'b1;
          end else begin
            cfg_s = 1'b0;
          end
        end else begin
          cfg_s = 1'b0;
        end
      end
      default: state_s = ST_PLAY;
    endcase

    next_gain_s = table_s[band_lsb(band_s) +: GAIN_W];
  end

  // UI register bank; o_gain is registered from the same next values as band and table.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= ST_INIT;
      menu_r   <= MENU_EQ;
      band_r   <= 3'd1;
      table_r  <= {TBL_W{1'b0}};
      offset_r <= 3'd0;
      play_r   <= 1'b0;
      cfg_r    <= 1'b0;
      gain_r   <= 32'd0;
    end else begin
      state_r  <= state_s;
      menu_r   <= menu_s;
      band_r   <= band_s;
      table_r  <= table_s;
      offset_r <= offset_s;
      play_r   <= play_s;
      cfg_r    <= cfg_s;
      gain_r   <= sext_gain(next_gain_s);
    end
  end

  assign o_state       = state_r;
  assign o_menu_state  = {1'b0, menu_r};
  assign o_band        = band_r;
  assign o_gain        = gain_r;
  assign o_gain_table  = table_r;
  assign o_offset      = offset_r;
  assign o_play_enable = play_r;
  assign o_cfg_update  = cfg_r;

endmodule

// File: tb/tb_ui_menu_controller.sv
// Directed self-checking bench for ui_menu_controller.
module tb_ui_menu_controller;

  localparam logic [3:0] K_NONE  = 4'b0000;
  localparam logic [3:0] K_BACK  = 4'b1000;
  localparam logic [3:0] K_ENTER = 4'b0100;
  localparam logic [3:0] K_UP    = 4'b0010;
  localparam logic [3:0] K_DOWN  = 4'b0001;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_init_done;
  logic [3:0]  keys;
  logic [2:0]  o_state, o_menu_state, o_band, o_offset;
  logic [31:0] o_gain;
  logic [29:0] o_gain_table;
  logic        o_play_enable, o_cfg_update;

  int errors = 0;
  int checks = 0;
  int cfg_cnt = 0;
  int snap;

  ui_menu_controller dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_init_done   (i_init_done),
    .i_key_up      (keys[1]),
    .i_key_down    (keys[0]),
    .i_key_enter   (keys[2]),
    .i_key_back    (keys[3]),
    .o_state       (o_state),
    .o_menu_state  (o_menu_state),
    .o_band        (o_band),
    .o_gain        (o_gain),
    .o_gain_table  (o_gain_table),
    .o_offset      (o_offset),
    .o_play_enable (o_play_enable),
    .o_cfg_update  (o_cfg_update)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_cfg_update) cfg_cnt <= cfg_cnt + 1;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    keys = k;
    tick();
    keys = K_NONE;
    tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_init_done = 1'b0; keys = K_NONE;
    tick(); tick();
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", o_state); end
    checks++; if (o_menu_state !== 3'd0) begin errors++; $display("FAIL reset_menu got %0d want 0", o_menu_state); end
    checks++; if (o_band !== 3'd1) begin errors++; $display("FAIL reset_band got %0d want 1", o_band); end
    checks++; if (o_gain !== 32'd0 || o_gain_table !== 30'd0) begin errors++; $display("FAIL reset_gain got %h/%h want 0/0", o_gain, o_gain_table); end
    checks++; if (o_offset !== 3'd0 || o_play_enable !== 1'b0 || o_cfg_update !== 1'b0) begin errors++; $display("FAIL reset_misc got ofs=%0d play=%b cfg=%b want 0/0/0", o_offset, o_play_enable, o_cfg_update); end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_init_play();
    press(K_UP);
    checks++; if (o_state !== 3'd0 || o_play_enable !== 1'b0) begin errors++; $display("FAIL init_ignores_keys got st=%0d play=%b want 0/0", o_state, o_play_enable); end
    i_init_done = 1'b1;
    tick();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL init_to_play got %0d want 1", o_state); end
    keys = K_UP;
    tick();
    checks++; if (o_play_enable !== 1'b1) begin errors++; $display("FAIL play_toggle got %b want 1", o_play_enable); end
    repeat (10) tick();
    checks++; if (o_play_enable !== 1'b1) begin errors++; $display("FAIL play_hold got %b want 1", o_play_enable); end
    keys = K_NONE;
    tick();
    checks++; if (cfg_cnt !== 0) begin errors++; $display("FAIL play_no_cfg got %0d want 0", cfg_cnt); end
  endtask

  task automatic test_band_gain();
    press(K_ENTER);
    checks++; if (o_state !== 3'd2 || o_menu_state !== 3'd0) begin errors++; $display("FAIL enter_menu got st=%0d m=%0d want 2/0", o_state, o_menu_state); end
    press(K_ENTER);
    checks++; if (o_state !== 3'd3 || o_band !== 3'd1) begin errors++; $display("FAIL enter_band got st=%0d b=%0d want 3/1", o_state, o_band); end
    press(K_DOWN);
    checks++; if (o_band !== 3'd6) begin errors++; $display("FAIL band_wrap_down got %0d want 6", o_band); end
    press(K_ENTER);
    checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL enter_gain got %0d want 4", o_state); end
    snap = cfg_cnt;
    repeat (3) press(K_UP);
    checks++; if (o_gain !== 32'd3) begin errors++; $display("FAIL gain_up got %h want 3", o_gain); end
    checks++; if (o_gain_table[29:25] !== 5'b00011) begin errors++; $display("FAIL gain_table_b6 got %b want 00011", o_gain_table[29:25]); end
    checks++; if (cfg_cnt - snap !== 3) begin errors++; $display("FAIL gain_up_pulses got %0d want 3", cfg_cnt - snap); end
  endtask

  task automatic test_gain_sat();
    press(K_BACK);
    press(K_UP);
    checks++; if (o_band !== 3'd1) begin errors++; $display("FAIL band_wrap_up got %0d want 1", o_band); end
    press(K_UP);
    press(K_ENTER);
    snap = cfg_cnt;
    repeat (30) press(K_DOWN);
    checks++; if (o_gain !== 32'hFFFF_FFF4) begin errors++; $display("FAIL gain_sat got %h want fffffff4", o_gain); end
    checks++; if (o_gain_table !== {5'b00011, 15'd0, 5'b10100, 5'd0}) begin errors++; $display("FAIL gain_sat_table got %h want %h", o_gain_table, {5'b00011, 15'd0, 5'b10100, 5'd0}); end
    checks++; if (cfg_cnt - snap !== 12) begin errors++; $display("FAIL gain_sat_pulses got %0d want 12", cfg_cnt - snap); end
  endtask

  task automatic test_offset();
    press(K_BACK);
    press(K_BACK);
    press(K_UP);
    checks++; if (o_state !== 3'd2 || o_menu_state !== 3'd1) begin errors++; $display("FAIL menu_up got st=%0d m=%0d want 2/1", o_state, o_menu_state); end
    press(K_ENTER);
    checks++; if (o_state !== 3'd5) begin errors++; $display("FAIL enter_offset got %0d want 5", o_state); end
    snap = cfg_cnt;
    repeat (6) press(K_UP);
    checks++; if (o_offset !== 3'd4) begin errors++; $display("FAIL offset_sat got %0d want 4", o_offset); end
    checks++; if (cfg_cnt - snap !== 4) begin errors++; $display("FAIL offset_pulses got %0d want 4", cfg_cnt - snap); end
    press(K_BACK);
    checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL offset_back got %0d want 2", o_state); end
  endtask

  task automatic test_priority();
    press(K_DOWN);
    press(K_ENTER);
    press(K_UP);
    checks++; if (o_state !== 3'd3 || o_band !== 3'd2) begin errors++; $display("FAIL prio_setup got st=%0d b=%0d want 3/2", o_state, o_band); end
    press(K_BACK | K_UP);
    checks++; if (o_state !== 3'd2 || o_band !== 3'd2) begin errors++; $display("FAIL prio_back_up got st=%0d b=%0d want 2/2", o_state, o_band); end
  endtask

  task automatic test_reset_mid();
    press(K_UP);
    press(K_ENTER);
    press(K_DOWN);
    checks++; if (o_offset !== 3'd3) begin errors++; $display("FAIL offset_down got %0d want 3", o_offset); end
    snap = cfg_cnt;
    keys = K_ENTER;
    i_rst = 1'b1;
    tick(); tick();
    checks++; if (o_state !== 3'd0 || o_band !== 3'd1 || o_menu_state !== 3'd0) begin errors++; $display("FAIL midreset_nav got st=%0d b=%0d m=%0d want 0/1/0", o_state, o_band, o_menu_state); end
    checks++; if (o_gain_table !== 30'd0 || o_gain !== 32'd0 || o_offset !== 3'd0 || o_play_enable !== 1'b0) begin errors++; $display("FAIL midreset_vals got t=%h g=%h o=%0d p=%b want 0", o_gain_table, o_gain, o_offset, o_play_enable); end
    i_rst = 1'b0;
    repeat (4) tick();
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL held_enter_ignored got %0d want 1", o_state); end
    checks++; if (cfg_cnt !== snap) begin errors++; $display("FAIL midreset_no_cfg got %0d want %0d", cfg_cnt, snap); end
    keys = K_NONE;
    tick();
    press(K_ENTER);
    checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL enter_after_release got %0d want 2", o_state); end
  endtask

  task automatic test_reset_menu();
    press(K_ENTER);
    press(K_ENTER);
    press(K_UP);
    press(K_UP);
    checks++; if (o_gain !== 32'd2 || o_gain_table !== 30'd2) begin errors++; $display("FAIL rm_gain_setup got %h/%h want 2/2", o_gain, o_gain_table); end
    press(K_BACK);
    press(K_BACK);
    press(K_UP);
    press(K_ENTER);
    press(K_UP);
    press(K_BACK);
    press(K_UP);
    checks++; if (o_menu_state !== 3'd2 || o_offset !== 3'd1) begin errors++; $display("FAIL rm_setup got m=%0d o=%0d want 2/1", o_menu_state, o_offset); end
    snap = cfg_cnt;
    press(K_ENTER);
    checks++; if (o_state !== 3'd1 || o_gain_table !== 30'd0 || o_offset !== 3'd0 || o_gain !== 32'd0) begin errors++; $display("FAIL rm_clear got st=%0d t=%h o=%0d g=%h want 1/0/0/0", o_state, o_gain_table, o_offset, o_gain); end
    checks++; if (cfg_cnt - snap !== 1) begin errors++; $display("FAIL rm_pulse got %0d want 1", cfg_cnt - snap); end
    press(K_UP);
    press(K_ENTER);
    press(K_DOWN);
    checks++; if (o_menu_state !== 3'd2) begin errors++; $display("FAIL menu_wrap_down got %0d want 2", o_menu_state); end
    snap = cfg_cnt;
    press(K_ENTER);
    checks++; if (cfg_cnt - snap !== 1) begin errors++; $display("FAIL rm_zero_pulse got %0d want 1", cfg_cnt - snap); end
    checks++; if (o_play_enable !== 1'b1) begin errors++; $display("FAIL play_retained got %b want 1", o_play_enable); end
  endtask

  initial begin
    keys = K_NONE;
    i_rst = 1'b1;
    i_init_done = 1'b0;
    test_reset();
    test_init_play();
    test_band_gain();
    test_gain_sat();
    test_offset();
    test_priority();
    test_reset_mid();
    test_reset_menu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
